// File: rtl/bmp_write_stage_if.sv
// Frame-memory write port seen by bmp_write_stage.
//
// Handshake: the master holds mem_Write_En, mem_Address and mem_Data
// stable until the slave returns mem_Ready; a word transfers on every
// rising clk edge where mem_Write_En and mem_Ready are both 1. The
// master never withdraws a pending word except on a frame restart or reset.
//
// Signals:
//   mem_Write_En  master->slave  write request (valid)
//   mem_Address   master->slave  word address, ADDR_WIDTH bits
//   mem_Data      master->slave  {R_Even,G_Even,B_Even,R_Odd,G_Odd,B_Odd}
//   mem_Ready     slave->master  write accepted this cycle
interface bmp_write_stage_if #(
   parameter int ADDR_WIDTH = 18
);
   logic                  mem_Write_En;
   logic [ADDR_WIDTH-1:0] mem_Address;
   logic [47:0]           mem_Data;
   logic                  mem_Ready;

   modport master (
      output mem_Write_En,
      output mem_Address,
      output mem_Data,
      input  mem_Ready
   );

   modport slave (
      input  mem_Write_En,
      input  mem_Address,
      input  mem_Data,
      output mem_Ready
   );
endinterface

// File: rtl/bmp_write_stage.sv
// BMP write stage: buffers even/odd RGB pixel pairs in a small FIFO and
// writes them, one pair per 48-bit word, into a frame memory using BMP
// bottom-up (or optional top-down) row addressing.
//
// Ports:
//   clk               single clock, rising edge
//   reset             asynchronous, active-high
//   vertical_Pulse    frame sync; a rising edge starts/restarts a frame
//   horizontal_Pulse  1 = the data_* inputs hold one valid pair
//   data_{R,G,B}_Even / data_{R,G,B}_Odd  8-bit pixel components
//   mem               write port (master side of bmp_write_stage_if)
//   done_Flag         all IMAGE_WIDTH*IMAGE_HEIGHT/2 words written
//   overflow_Flag     sticky: a pair was dropped on a full FIFO
//   fsm_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
module bmp_write_stage #(
   parameter int IMAGE_WIDTH  = 768,
   parameter int IMAGE_HEIGHT = 512,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_WIDTH   = 18,
   parameter int BOTTOM_UP    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vertical_Pulse,
   input  logic                horizontal_Pulse,
   input  logic [7:0]          data_R_Even,
   input  logic [7:0]          data_G_Even,
   input  logic [7:0]          data_B_Even,
   input  logic [7:0]          data_R_Odd,
   input  logic [7:0]          data_G_Odd,
   input  logic [7:0]          data_B_Odd,
   bmp_write_stage_if.master   mem,
   output logic                done_Flag,
   output logic                overflow_Flag,
   output logic [1:0]          fsm_state
);

   localparam int TOTAL  = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
   localparam int HALF_W = IMAGE_WIDTH / 2;
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam int COL_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] TOTAL_M1  = CNT_W'(TOTAL - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(HALF_W - 1);
   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]      H_M1_C    = 32'(IMAGE_HEIGHT - 1);
   localparam logic [31:0]      HALF_W_C  = 32'(HALF_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             vp_q;
   logic             fs;
   logic [47:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty;
   logic             capture, push, pop, drop_full, accept, last_accept;
   logic [CNT_W-1:0] push_cnt, acc_cnt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [31:0]      row_eff;
   logic [47:0]      pair_in;

   assign pair_in = {data_R_Even, data_G_Even, data_B_Even,
                     data_R_Odd,  data_G_Odd,  data_B_Odd};

   assign fs    = vertical_Pulse & ~vp_q;
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // Pairs beyond one frame's worth are discarded silently; only a full
   // FIFO within the frame counts as data loss. A pop in the same cycle
   // does not rescue a pair arriving at a full FIFO.
   assign capture   = (state == RUN) && !fs && horizontal_Pulse && (push_cnt != TOTAL_C);
   assign push      = capture && !full;
   assign drop_full = capture && full;

   assign accept      = mem.mem_Write_En && mem.mem_Ready;
   assign last_accept = accept && (acc_cnt == TOTAL_M1);

   // The output register refills whenever it is free or being emptied this
   // edge, which gives one word per cycle under a continuously ready memory.
   assign pop = !fs && !empty && (!mem.mem_Write_En || mem.mem_Ready);

   assign row_eff = (BOTTOM_UP != 0) ? (H_M1_C - 32'(row)) : 32'(row);

   assign fsm_state = state;

   // Frame-sync edge detector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vp_q <= 1'b0;
      else       vp_q <= vertical_Pulse;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state and decoded outputs
   always_comb begin
      state_nxt = state;
      done_Flag = 1'b0;
      case (state)
         IDLE: begin
            if (fs) state_nxt = RUN;
         end
         RUN: begin
            if (fs)               state_nxt = RUN;
            else if (last_accept) state_nxt = DONE;
         end
         DONE: begin
            done_Flag = 1'b1;
            if (fs) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= pair_in;
   end

   // FIFO pointers, frame counters, output register and overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         push_cnt         <= '0;
         acc_cnt          <= '0;
         col              <= '0;
         row              <= '0;
         overflow_Flag    <= 1'b0;
         mem.mem_Write_En <= 1'b0;
         mem.mem_Address  <= '0;
         mem.mem_Data     <= '0;
      end else if (fs) begin
         // Restart: flush everything and abandon any pending word
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         push_cnt         <= '0;
         acc_cnt          <= '0;
         col              <= '0;
         row              <= '0;
         overflow_Flag    <= 1'b0;
         mem.mem_Write_En <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            push_cnt <= push_cnt + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop_full) overflow_Flag <= 1'b1;
         if (accept)    acc_cnt <= acc_cnt + 1'b1;

         if (pop) begin
            mem.mem_Write_En <= 1'b1;
            mem.mem_Address  <= ADDR_WIDTH'(row_eff * HALF_W_C + 32'(col));
            mem.mem_Data     <= fifo_mem[rd_ptr];
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else if (accept) begin
            mem.mem_Write_En <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bmp_write_stage.sv
// Directed testbench for bmp_write_stage on an 8x4 image with a 4-entry
// FIFO. Two instances share all stimulus: dut_a uses bottom-up rows,
// dut_b top-down rows. Inputs are driven and outputs sampled 1 time unit
// after each rising clock edge.
module tb_bmp_write_stage;

   logic       clk;
   logic       reset;
   logic       vertical_Pulse;
   logic       horizontal_Pulse;
   logic [7:0] data_R_Even, data_G_Even, data_B_Even;
   logic [7:0] data_R_Odd,  data_G_Odd,  data_B_Odd;
   logic       ready;
   logic       done_a, ovf_a, done_b, ovf_b;
   logic [1:0] st_a, st_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Bottom-up addresses for words 0..15 of an 8x4 image (4 words per row)
   int bu_tab [16] = '{12, 13, 14, 15, 8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

   bmp_write_stage_if #(.ADDR_WIDTH(4)) mem_a ();
   bmp_write_stage_if #(.ADDR_WIDTH(4)) mem_b ();

   assign mem_a.mem_Ready = ready;
   assign mem_b.mem_Ready = ready;

   bmp_write_stage #(
      .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .FIFO_DEPTH(4), .ADDR_WIDTH(4), .BOTTOM_UP(1)
   ) dut_a (
      .clk(clk), .reset(reset),
      .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
      .data_R_Even(data_R_Even), .data_G_Even(data_G_Even), .data_B_Even(data_B_Even),
      .data_R_Odd(data_R_Odd), .data_G_Odd(data_G_Odd), .data_B_Odd(data_B_Odd),
      .mem(mem_a), .done_Flag(done_a), .overflow_Flag(ovf_a), .fsm_state(st_a)
   );

   bmp_write_stage #(
      .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .FIFO_DEPTH(4), .ADDR_WIDTH(4), .BOTTOM_UP(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
      .data_R_Even(data_R_Even), .data_G_Even(data_G_Even), .data_B_Even(data_B_Even),
      .data_R_Odd(data_R_Odd), .data_G_Odd(data_G_Odd), .data_B_Odd(data_B_Odd),
      .mem(mem_b), .done_Flag(done_b), .overflow_Flag(ovf_b), .fsm_state(st_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   function automatic logic [47:0] pix(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {b, ~b, b ^ 8'h5a, b + 8'd1, b + 8'd2, b + 8'd3};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input int k);
      horizontal_Pulse = 1'b1;
      {data_R_Even, data_G_Even, data_B_Even, data_R_Odd, data_G_Odd, data_B_Odd} = pix(k);
   endtask

   task automatic drive_idle();
      horizontal_Pulse = 1'b0;
   endtask

   task automatic fs_pulse();
      vertical_Pulse = 1'b1;
      step();
      vertical_Pulse = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; vertical_Pulse = 1'b0; ready = 1'b1;
      drive_pair(0); drive_idle();
      step(); step();
      n_checks++; if (mem_a.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", mem_a.mem_Write_En); end
      n_checks++; if (mem_a.mem_Address !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_a.mem_Address); end
      n_checks++; if (mem_a.mem_Data !== 48'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", mem_a.mem_Data); end
      n_checks++; if ({done_a, ovf_a, done_b, ovf_b} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {done_a, ovf_a, done_b, ovf_b}); end
      n_checks++; if ({st_a, st_b} !== 4'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0000", {st_a, st_b}); end
      reset = 1'b0;
      step();
      // Pairs presented while IDLE must be ignored
      for (int i = 0; i < 4; i++) begin
         drive_pair(200 + i);
         step();
         n_checks++; if (mem_a.mem_Write_En !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL idle_ignore[%0d]: we=%0b state=%0d expected we=0 state=0", i, mem_a.mem_Write_En, st_a); end
      end
      drive_idle();
      step(); step();
      n_checks++; if (mem_a.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL idle_drain: got we=%0b expected 0", mem_a.mem_Write_En); end
   endtask

   // 19 consecutive pairs: 16 fill the frame, the last 3 exceed the cap
   task automatic test_frame();
      ready = 1'b1;
      fs_pulse();
      n_checks++; if (st_a !== 2'd1) begin n_fail++; $display("FAIL frame_run: state %0d expected 1", st_a); end
      for (int cyc = 0; cyc <= 20; cyc++) begin
         if (cyc < 19) drive_pair(cyc); else drive_idle();
         step();
         if (cyc == 0) begin
            n_checks++; if (mem_a.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL frame_latency: we=%0b one cycle after first pair, expected 0", mem_a.mem_Write_En); end
         end
         if (cyc >= 1 && cyc <= 16) begin
            n_checks++; if (mem_a.mem_Write_En !== 1'b1) begin n_fail++; $display("FAIL frame_we[%0d]: got %0b expected 1", cyc - 1, mem_a.mem_Write_En); end
            n_checks++; if (mem_a.mem_Address !== 4'(bu_tab[cyc - 1])) begin n_fail++; $display("FAIL frame_addr_bu[%0d]: got %0d expected %0d", cyc - 1, mem_a.mem_Address, bu_tab[cyc - 1]); end
            n_checks++; if (mem_a.mem_Data !== pix(cyc - 1)) begin n_fail++; $display("FAIL frame_data[%0d]: got %h expected %h", cyc - 1, mem_a.mem_Data, pix(cyc - 1)); end
            n_checks++; if (mem_b.mem_Address !== 4'(cyc - 1)) begin n_fail++; $display("FAIL frame_addr_td[%0d]: got %0d expected %0d", cyc - 1, mem_b.mem_Address, cyc - 1); end
            n_checks++; if (mem_b.mem_Data[47:40] !== 8'(cyc - 1)) begin n_fail++; $display("FAIL frame_data_td[%0d]: got %0d expected %0d", cyc - 1, mem_b.mem_Data[47:40], cyc - 1); end
         end
         if (cyc == 16) begin
            n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL frame_done_early: got %0b expected 0", done_a); end
         end
         if (cyc >= 17) begin
            n_checks++; if (mem_a.mem_Write_En !== 1'b0 || mem_b.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL frame_extra_write[%0d]: we_a=%0b we_b=%0b expected 0", cyc, mem_a.mem_Write_En, mem_b.mem_Write_En); end
            n_checks++; if (done_a !== 1'b1 || done_b !== 1'b1) begin n_fail++; $display("FAIL frame_done[%0d]: a=%0b b=%0b expected 1", cyc, done_a, done_b); end
         end
      end
      n_checks++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin n_fail++; $display("FAIL frame_no_ovf: a=%0b b=%0b expected 0", ovf_a, ovf_b); end
   endtask

   task automatic test_done_ignore();
      for (int i = 0; i < 4; i++) begin
         drive_pair(150 + i);
         step();
         n_checks++; if (mem_a.mem_Write_En !== 1'b0 || done_a !== 1'b1 || ovf_a !== 1'b0 || st_a !== 2'd2) begin n_fail++; $display("FAIL done_ignore[%0d]: we=%0b done=%0b ovf=%0b state=%0d expected 0 1 0 2", i, mem_a.mem_Write_En, done_a, ovf_a, st_a); end
      end
      drive_idle();
   endtask

   // 10-pair burst into a stalled memory: 1 in output register + 4 in FIFO survive
   task automatic test_stall();
      ready = 1'b0;
      fs_pulse();
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL stall_done_clear: got %0b expected 0", done_a); end
      for (int cyc = 0; cyc < 10; cyc++) begin
         drive_pair(32 + cyc);
         step();
         if (cyc >= 1) begin
            n_checks++; if (mem_a.mem_Write_En !== 1'b1 || mem_a.mem_Address !== 4'd12 || mem_a.mem_Data !== pix(32)) begin n_fail++; $display("FAIL stall_hold[%0d]: we=%0b addr=%0d data=%h expected 1 12 %h", cyc, mem_a.mem_Write_En, mem_a.mem_Address, mem_a.mem_Data, pix(32)); end
         end
         if (cyc == 4) begin
            n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL stall_ovf_early: got %0b expected 0", ovf_a); end
         end
         if (cyc == 5) begin
            n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL stall_ovf_set: got %0b expected 1", ovf_a); end
         end
      end
      drive_idle();
      for (int j = 0; j < 5; j++) begin
         n_checks++; if (mem_a.mem_Write_En !== 1'b1 || mem_a.mem_Address !== 4'(bu_tab[j]) || mem_a.mem_Data !== pix(32 + j)) begin n_fail++; $display("FAIL stall_drain[%0d]: we=%0b addr=%0d data=%h expected 1 %0d %h", j, mem_a.mem_Write_En, mem_a.mem_Address, mem_a.mem_Data, bu_tab[j], pix(32 + j)); end
         ready = 1'b1;
         step();
      end
      n_checks++; if (mem_a.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL stall_retained: we=%0b after 5 words, expected 0", mem_a.mem_Write_En); end
      n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL stall_ovf_sticky: got %0b expected 1", ovf_a); end
   endtask

   // Frame sync arrives after 7 accepted words while more are in flight
   task automatic test_restart();
      ready = 1'b1;
      fs_pulse();
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL restart_ovf_clear: got %0b expected 0", ovf_a); end
      for (int cyc = 0; cyc < 10; cyc++) begin
         drive_pair(64 + cyc);
         if (cyc == 9) vertical_Pulse = 1'b1;
         step();
         if (cyc >= 1 && cyc <= 8) begin
            n_checks++; if (mem_a.mem_Write_En !== 1'b1 || mem_a.mem_Address !== 4'(bu_tab[cyc - 1])) begin n_fail++; $display("FAIL restart_pre[%0d]: we=%0b addr=%0d expected 1 %0d", cyc - 1, mem_a.mem_Write_En, mem_a.mem_Address, bu_tab[cyc - 1]); end
         end
      end
      n_checks++; if (mem_a.mem_Write_En !== 1'b0 || st_a !== 2'd1 || done_a !== 1'b0) begin n_fail++; $display("FAIL restart_drop: we=%0b state=%0d done=%0b expected 0 1 0", mem_a.mem_Write_En, st_a, done_a); end
      vertical_Pulse = 1'b0;
      drive_pair(99);
      step();
      n_checks++; if (mem_a.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL restart_flush: we=%0b expected 0", mem_a.mem_Write_En); end
      drive_idle();
      step();
      n_checks++; if (mem_a.mem_Write_En !== 1'b1 || mem_a.mem_Address !== 4'd12 || mem_a.mem_Data !== pix(99)) begin n_fail++; $display("FAIL restart_first: we=%0b addr=%0d data=%h expected 1 12 %h", mem_a.mem_Write_En, mem_a.mem_Address, mem_a.mem_Data, pix(99)); end
      step();
   endtask

   task automatic test_async_reset();
      ready = 1'b0;
      fs_pulse();
      drive_pair(7);
      step();
      drive_idle();
      step();
      n_checks++; if (mem_a.mem_Write_En !== 1'b1 || mem_a.mem_Data !== pix(7)) begin n_fail++; $display("FAIL areset_pre: we=%0b data=%h expected 1 %h", mem_a.mem_Write_En, mem_a.mem_Data, pix(7)); end
      #3;
      reset = 1'b1;
      #1;
      n_checks++; if (mem_a.mem_Write_En !== 1'b0 || mem_b.mem_Write_En !== 1'b0) begin n_fail++; $display("FAIL areset_we: a=%0b b=%0b expected 0", mem_a.mem_Write_En, mem_b.mem_Write_En); end
      n_checks++; if (mem_a.mem_Address !== 4'd0 || mem_a.mem_Data !== 48'd0) begin n_fail++; $display("FAIL areset_bus: addr=%0d data=%h expected 0 0", mem_a.mem_Address, mem_a.mem_Data); end
      n_checks++; if ({done_a, ovf_a, st_a, st_b} !== 6'b0) begin n_fail++; $display("FAIL areset_state: got %b expected 000000", {done_a, ovf_a, st_a, st_b}); end
      #2;
      reset = 1'b0;
      ready = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         drive_pair(180 + i);
         step();
         n_checks++; if (mem_a.mem_Write_En !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL areset_idle[%0d]: we=%0b state=%0d expected 0 0", i, mem_a.mem_Write_En, st_a); end
      end
      drive_idle();
      fs_pulse();
      n_checks++; if (st_a !== 2'd1) begin n_fail++; $display("FAIL areset_fs: state %0d expected 1", st_a); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_frame();
      test_done_ignore();
      test_stall();
      test_restart();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bmp_write_stage.md
Name: bmp_write_stage

Overview:
- Downstream neighbour of the image read/threshold stage.
- Consumes the even/odd RGB pixel pairs that stage emits while horizontal_Pulse is high.
- Buffers the pairs in a small FIFO and writes them, one pair per word, into a frame memory write port using BMP bottom-up row addressing.
- Reports frame completion (done_Flag) and sticky data loss (overflow_Flag).

Parameters:
- IMAGE_WIDTH, 768, pixels per row; must be even.
- IMAGE_HEIGHT, 512, rows per frame.
- FIFO_DEPTH, 8, pixel-pair entries in the input FIFO; power of two, at least 2.
- ADDR_WIDTH, 18, memory word address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT/2.
- BOTTOM_UP, 1, 1 = BMP row order (last image row at address 0); 0 = top-down order.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- vertical_Pulse  input  1  frame sync; its rising edge starts a frame.
- horizontal_Pulse  input  1  pair-valid qualifier; 1 = data inputs hold one valid pair this cycle.
- data_R_Even, data_G_Even, data_B_Even  input  8 each  even-pixel RGB.
- data_R_Odd, data_G_Odd, data_B_Odd  input  8 each  odd-pixel RGB.
- mem_Write_En  output  1  write request (valid).
- mem_Address  output  ADDR_WIDTH  word address.
- mem_Data  output  48  packed word: {R_Even,G_Even,B_Even,R_Odd,G_Odd,B_Odd}, R_Even in bits 47:40.
- mem_Ready  input  1  memory accepts the write this cycle.
- done_Flag  output  1  all IMAGE_WIDTH*IMAGE_HEIGHT/2 words of the frame written.
- overflow_Flag  output  1  sticky; at least one pair dropped on a full FIFO.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; FIFO empty; col/row counters = 0.
  - mem_Write_En = 0; mem_Address = 0; mem_Data = 0.
  - done_Flag = 0; overflow_Flag = 0.
- Frame start (fs): vertical_Pulse registered; fs = current vertical_Pulse high and previous sample low.
- States:
  - IDLE: horizontal_Pulse ignored. On fs -> RUN.
  - RUN: capture and write. After the last word is accepted -> DONE.
  - DONE: done_Flag = 1. Further pairs ignored. On fs -> RUN.
- fs while in RUN or DONE, applied on the next edge:
  - flush the FIFO; drop any pending write (mem_Write_En = 0);
  - clear counters, done_Flag and overflow_Flag;
  - enter RUN.
  - The pair present in the fs cycle itself is ignored.
- Capture in RUN: each cycle with horizontal_Pulse = 1 pushes one pair.
  - If the FIFO is full, the pair is dropped and overflow_Flag is set. This holds even if a pop occurs in the same cycle.
  - Total pushes per frame are capped at IMAGE_WIDTH*IMAGE_HEIGHT/2; any excess pairs are dropped without setting overflow_Flag.
- Output register (valid/ready):
  - Loaded from the FIFO head when the FIFO is not empty and (mem_Write_En = 0 or mem_Ready = 1).
  - While mem_Write_En = 1 and mem_Ready = 0, mem_Address and mem_Data hold stable.
  - A write is accepted on an edge where mem_Write_En and mem_Ready are both 1.
  - After acceptance, mem_Write_En drops only if no new entry is loaded that cycle. Back-to-back writes give 1 word per cycle.
- Latency: a pair pushed at edge t, with the FIFO empty and the output register free, is on mem_* after edge t+1 (visible two cycles after the cycle it was presented).
- Addressing:
  - col = 0..IMAGE_WIDTH/2-1; row = 0..IMAGE_HEIGHT-1.
  - Counters advance at load time: col increments; on wrap col -> 0 and row increments.
  - BOTTOM_UP = 1: address = (IMAGE_HEIGHT-1-row)*(IMAGE_WIDTH/2) + col.
  - BOTTOM_UP = 0: address = row*(IMAGE_WIDTH/2) + col.
  - Computed at full precision, then truncated to ADDR_WIDTH.
- Completion: on acceptance of word IMAGE_WIDTH*IMAGE_HEIGHT/2, done_Flag = 1 from the next cycle. It holds until the next fs or reset.
- FIFO: circular, with pointer wrap at FIFO_DEPTH. Full/empty are derived from an occupancy counter. A simultaneous push and pop leaves occupancy unchanged.

Test Plan:
- IMAGE_WIDTH=8, IMAGE_HEIGHT=4, BOTTOM_UP=1, mem_Ready tied 1; fs, then 16 consecutive pairs with R_Even = 0..15:
  - addresses are 12,13,14,15,8,...,3;
  - first mem_Write_En appears 2 cycles after the first pair;
  - done_Flag rises 1 cycle after the 16th accept.
- Same setup with BOTTOM_UP=0 -> addresses 0..15 in order; mem_Data for pair k has bits 47:40 = k.
- FIFO_DEPTH=4, mem_Ready=0 for 10 cycles during a 10-pair burst:
  - exactly 5 pairs are retained (4 in FIFO + 1 in output register);
  - overflow_Flag = 1;
  - address/data stay stable while stalled; after release, the retained 5 are written in order.
- fs after 7 accepted words:
  - mem_Write_En = 0 on the next cycle; FIFO flushed; overflow_Flag cleared;
  - the next pair is written to address 12 (BOTTOM_UP=1).
- horizontal_Pulse pulses in IDLE and in DONE, plus 3 extra pairs after the 16th -> no writes; overflow_Flag stays 0.
- reset asserted mid-write, asynchronously between edges -> all outputs 0 immediately; state IDLE until the next vertical_Pulse rising edge.
